// File: rtl/capture_timer.sv
// 32-bit input-capture timer: timestamps or measures period/width of edges on capin.
// Optional glitch filter on the synchronized input is built when CAPTURE_FILTER_EN is defined.
module capture_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic        clkin,
    input  logic        resetn,
    input  logic        capin,
    input  logic        reg_cfg_we,
    input  logic [31:0] reg_cfg_di,
    output logic [31:0] reg_cfg_do,
    input  logic [3:0]  reg_cnt_we,
    input  logic [31:0] reg_cnt_di,
    output logic [31:0] reg_cnt_do,
    input  logic        reg_cap_rd,
    output logic [31:0] reg_cap_do,
    input  logic        reg_sts_we,
    input  logic [31:0] reg_sts_di,
    output logic [31:0] reg_sts_do,
    output logic        irq_out
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   level_prev_reg;
    logic                   synced;
    logic                   filt_level;

    logic [5:0]  cfg_reg, cfg_next;
    logic [31:0] cnt_reg, cnt_next, cnt_merged;
    logic [31:0] cap_reg;
    logic        cap_valid_reg, cap_valid_next;
    logic        overrun_reg, overrun_next;
    logic        cnt_ovf_reg, cnt_ovf_next;
    logic        irq_reg;

    logic enable, rise, fall, edge_det, cnt_written, cnt_wrap;

    wire unused_di = &{1'b0, reg_cfg_di[31:6], reg_sts_di[31:3]};

    assign synced = sync_reg[SYNC_STAGES-1];

    // Synchronizer and previous-level flop run regardless of enable so re-enabling never sees a stale edge.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            sync_reg       <= '0;
            level_prev_reg <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], capin};
            level_prev_reg <= filt_level;
        end
    end

`ifdef CAPTURE_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);
    logic [FCW-1:0] filt_cnt_reg;
    logic           filt_level_reg;

    // Filtered level follows synced only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            filt_cnt_reg   <= '0;
            filt_level_reg <= 1'b0;
        end else if (synced == filt_level_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_cnt_reg == FCW'(FILTER_LEN - 1)) begin
            filt_cnt_reg   <= '0;
            filt_level_reg <= synced;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    assign filt_level = filt_level_reg;
`else
    assign filt_level = synced;
`endif

    assign enable   = cfg_reg[0];
    assign rise     = filt_level & ~level_prev_reg;
    assign fall     = ~filt_level & level_prev_reg;
    assign edge_det = enable & ((cfg_reg[1] & rise) | (cfg_reg[2] & fall));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt_byte
            assign cnt_merged[8*gi +: 8] = reg_cnt_we[gi] ? reg_cnt_di[8*gi +: 8]
                                                          : cnt_reg[8*gi +: 8];
        end
    endgenerate

    assign cnt_written = |reg_cnt_we;
    assign cnt_wrap    = enable & ~cnt_written & ~(edge_det & cfg_reg[4]) & (&cnt_reg);

    // Bus byte writes beat clear-on-capture, which beats the normal increment.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_written)
            cnt_next = cnt_merged;
        else if (edge_det && cfg_reg[4])
            cnt_next = 32'd1;
        else if (enable)
            cnt_next = cnt_reg + 32'd1;
    end

    always_comb begin
        cfg_next = cfg_reg;
        if (edge_det && cfg_reg[5])
            cfg_next[0] = 1'b0;
        if (reg_cfg_we)
            cfg_next = reg_cfg_di[5:0];
    end

    // Set events take precedence over read/W1C clears in the same cycle.
    always_comb begin
        cap_valid_next = cap_valid_reg;
        overrun_next   = overrun_reg;
        cnt_ovf_next   = cnt_ovf_reg;
        if (reg_cap_rd || (reg_sts_we && reg_sts_di[0]))
            cap_valid_next = 1'b0;
        if (reg_sts_we && reg_sts_di[1])
            overrun_next = 1'b0;
        if (reg_sts_we && reg_sts_di[2])
            cnt_ovf_next = 1'b0;
        if (edge_det)
            cap_valid_next = 1'b1;
        if (edge_det && cap_valid_reg && !reg_cap_rd)
            overrun_next = 1'b1;
        if (cnt_wrap)
            cnt_ovf_next = 1'b1;
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            cfg_reg       <= '0;
            cnt_reg       <= '0;
            cap_reg       <= '0;
            cap_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            cnt_ovf_reg   <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            cfg_reg       <= cfg_next;
            cnt_reg       <= cnt_next;
            if (edge_det)
                cap_reg <= cnt_reg;
            cap_valid_reg <= cap_valid_next;
            overrun_reg   <= overrun_next;
            cnt_ovf_reg   <= cnt_ovf_next;
            irq_reg       <= cfg_reg[3] & (cap_valid_reg | overrun_reg | cnt_ovf_reg);
        end
    end

    assign reg_cfg_do = {26'd0, cfg_reg};
    assign reg_cnt_do = cnt_reg;
    assign reg_cap_do = cap_reg;
    assign reg_sts_do = {29'd0, cnt_ovf_reg, overrun_reg, cap_valid_reg};
    assign irq_out    = irq_reg;

endmodule

// File: tb/tb_capture_timer.sv
// Self-checking bench for capture_timer: scoreboard of expected capture values plus direct status checks.
`timescale 1ns/1ps
module tb_capture_timer;

`ifdef CAPTURE_FILTER_EN
    localparam int LAT = 2 + 4 + 1;
`else
    localparam int LAT = 2 + 1;
`endif

    logic        clkin, resetn, capin;
    logic        reg_cfg_we, reg_cnt_we_any;
    logic [31:0] reg_cfg_di, reg_cfg_do;
    logic [3:0]  reg_cnt_we;
    logic [31:0] reg_cnt_di, reg_cnt_do;
    logic        reg_cap_rd;
    logic [31:0] reg_cap_do;
    logic        reg_sts_we;
    logic [31:0] reg_sts_di, reg_sts_do;
    logic        irq_out;

    typedef struct {
        logic [31:0] val;
        bit          chk;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          auto_read = 0;

    capture_timer dut (
        .clkin      (clkin),
        .resetn     (resetn),
        .capin      (capin),
        .reg_cfg_we (reg_cfg_we),
        .reg_cfg_di (reg_cfg_di),
        .reg_cfg_do (reg_cfg_do),
        .reg_cnt_we (reg_cnt_we),
        .reg_cnt_di (reg_cnt_di),
        .reg_cnt_do (reg_cnt_do),
        .reg_cap_rd (reg_cap_rd),
        .reg_cap_do (reg_cap_do),
        .reg_sts_we (reg_sts_we),
        .reg_sts_di (reg_sts_di),
        .reg_sts_do (reg_sts_do),
        .irq_out    (irq_out)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    always @(posedge clkin) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic cfg_write(input logic [31:0] v);
        reg_cfg_di = v;
        reg_cfg_we = 1'b1;
        @(negedge clkin);
        reg_cfg_we = 1'b0;
    endtask

    task automatic cnt_write(input logic [31:0] v, input logic [3:0] we);
        reg_cnt_di = v;
        reg_cnt_we = we;
        @(negedge clkin);
        reg_cnt_we = 4'd0;
    endtask

    task automatic sts_write(input logic [31:0] v);
        reg_sts_di = v;
        reg_sts_we = 1'b1;
        @(negedge clkin);
        reg_sts_we = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] v, input bit chk);
        exp_t e;
        e.val = v;
        e.chk = chk;
        sb_q.push_back(e);
    endtask

    // Capture monitor: whenever cap_valid shows up, compare against the scoreboard and read it out.
    initial begin
        exp_t e;
        reg_cap_rd = 1'b0;
        forever begin
            @(negedge clkin);
            if (!auto_read) begin
                reg_cap_rd = 1'b0;
            end else if (reg_cap_rd) begin
                reg_cap_rd = 1'b0;
            end else if (reg_sts_do[0]) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", sb_q.size(), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk)
                        check("cap", reg_cap_do, e.val);
                end
                reg_cap_rd = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e_cyc, s_cyc, n;
        logic [31:0] exp1, exp2;
        exp_t        e;

        resetn = 1'b0; capin = 1'b0;
        reg_cfg_we = 1'b0; reg_cfg_di = '0;
        reg_cnt_we = '0; reg_cnt_di = '0; reg_cnt_we_any = 1'b0;
        reg_sts_we = 1'b0; reg_sts_di = '0;
        tick(3);
        resetn = 1'b1;
        tick(1);

        check("rst_cfg", reg_cfg_do, 32'd0);
        check("rst_cnt", reg_cnt_do, 32'd0);
        check("rst_cap", reg_cap_do, 32'd0);
        check("rst_sts", reg_sts_do, 32'd0);
        check("rst_irq", {31'd0, irq_out}, 32'd1 - 32'd1);

        // Period measurement: rising edges 100 cycles apart, counter cleared on capture.
        auto_read = 1;
        cfg_write(32'h13);
        for (int i = 0; i < 4; i++) begin
            push_exp(32'd100, i != 0);
            capin = 1'b1; tick(50);
            capin = 1'b0; tick(50);
        end
        check("period_sb_empty", sb_q.size(), 32'd0);
        check("period_no_ovr", {31'd0, reg_sts_do[1]}, 32'd0);
        cfg_write(32'h0);
        tick(2);

        // Pulse width: both edges, high 37 / low 63.
        cfg_write(32'h17);
        for (int i = 0; i < 3; i++) begin
            push_exp(32'd63, i != 0);
            capin = 1'b1; tick(37);
            push_exp(32'd37, 1'b1);
            capin = 1'b0; tick(63);
        end
        check("width_sb_empty", sb_q.size(), 32'd0);
        cfg_write(32'h0);
        tick(2);
        auto_read = 0;
        tick(2);

        // Overrun: two rising edges without reading, timestamps from a known counter base.
        sts_write(32'h7);
        cnt_write(32'd1000, 4'hF);
        cfg_write(32'h0B);
        e_cyc = cyc;
        tick(4);
        capin = 1'b1; s_cyc = cyc;
        exp1 = 32'd1000 + 32'(s_cyc - e_cyc) + 32'(LAT - 1);
        push_exp(exp1, 1'b1);
        tick(LAT + 1);
        e = sb_q.pop_front();
        check("ovr_cap1", reg_cap_do, e.val);
        check("ovr_sts1", reg_sts_do, 32'h1);
        capin = 1'b0; tick(5);
        capin = 1'b1; s_cyc = cyc;
        exp2 = 32'd1000 + 32'(s_cyc - e_cyc) + 32'(LAT - 1);
        push_exp(exp2, 1'b1);
        tick(LAT + 1);
        e = sb_q.pop_front();
        check("ovr_cap2", reg_cap_do, e.val);
        check("ovr_sts2", reg_sts_do, 32'h3);
        check("ovr_irq", {31'd0, irq_out}, 32'd1);
        sts_write(32'h3);
        check("ovr_sts_clr", reg_sts_do, 32'h0);
        check("ovr_irq_lag", {31'd0, irq_out}, 32'd1);
        tick(1);
        check("ovr_irq_clr", {31'd0, irq_out}, 32'd0);
        cfg_write(32'h0);
        capin = 1'b0;
        tick(5);

        // Counter wrap and byte-write priority.
        sts_write(32'h7);
        cnt_write(32'hFFFF_FFFE, 4'hF);
        cfg_write(32'h09);
        tick(1);
        check("wrap_cnt_max", reg_cnt_do, 32'hFFFF_FFFF);
        check("wrap_no_ovf", reg_sts_do, 32'h0);
        tick(1);
        check("wrap_cnt0", reg_cnt_do, 32'h0);
        check("wrap_ovf", reg_sts_do, 32'h4);
        tick(1);
        check("wrap_irq", {31'd0, irq_out}, 32'd1);
        cnt_write(32'h1234_AB56, 4'b0010);
        check("byte_wr", reg_cnt_do, 32'h0000_AB01);
        tick(1);
        check("byte_inc", reg_cnt_do, 32'h0000_AB02);
        cfg_write(32'h0);
        tick(5);
        check("freeze", reg_cnt_do, 32'h0000_AB03);
        sts_write(32'h7);

        // Oneshot with latency measurement.
        cnt_write(32'd0, 4'hF);
        cfg_write(32'h23);
        e_cyc = cyc;
        tick(3);
        capin = 1'b1; s_cyc = cyc;
        exp1 = 32'(s_cyc - e_cyc) + 32'(LAT - 1);
        push_exp(exp1, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clkin);
            n++;
            if (reg_sts_do[0]) break;
        end
        check("latency", n, LAT);
        e = sb_q.pop_front();
        check("oneshot_cap", reg_cap_do, e.val);
        check("oneshot_cfg", reg_cfg_do, 32'h22);
        capin = 1'b0; tick(5);
        capin = 1'b1; tick(10);
        check("oneshot_sts", reg_sts_do, 32'h1);
        check("oneshot_cnt", reg_cnt_do, exp1 + 32'd1);
        capin = 1'b0;
        sts_write(32'h7);
        tick(5);

`ifdef CAPTURE_FILTER_EN
        cfg_write(32'h03);
        capin = 1'b1; tick(3);
        capin = 1'b0; tick(15);
        check("filt_glitch", reg_sts_do, 32'h0);
        capin = 1'b1; tick(5);
        capin = 1'b0; tick(10);
        check("filt_pulse", reg_sts_do, 32'h1);
        cfg_write(32'h0);
        sts_write(32'h7);
`endif

        // Asynchronous reset in the middle of counting.
        cfg_write(32'h01);
        tick(5);
        #1 resetn = 1'b0;
        #1;
        check("arst_cnt", reg_cnt_do, 32'h0);
        check("arst_cfg", reg_cfg_do, 32'h0);
        @(negedge clkin);
        resetn = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
